spi_slave_os: RTL and testbench
===============================

# spi_slave_os

Oversampled, parametrised SPI slave running entirely in the system clock domain. SCLK, CS_N and MOSI are synchronised and edge-detected, and all four SPI modes plus LSB-first are supported by parameter. Back-to-back words within one chip-select frame are streamed through a ready/valid TX holding register and a one-cycle RX valid pulse. The block is the successor to our SCLK-clocked slave and sits between the pad ring and the register or host logic.

## Interface
- `WIDTH`, 8: bits per word, ≥2
- `CPOL`, 0: SCLK idle level
- `CPHA`, 0: 0 = sample on leading edge; 1 = sample on trailing edge
- `MSB_FIRST`, 1: bit order for both directions
- `SYNC_STAGES`, 2: synchroniser depth, ≥2
- `clk`  in  1  system clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `sclk`, `cs_n`, `mosi`  in  1  asynchronous SPI pins
- `miso`  out  1  serial data out
- `miso_oe`  out  1  high while frame active (pad tristate control)
- `tx_data`  in  WIDTH  next word to transmit
- `tx_valid`  in  1  tx_data valid
- `tx_ready`  out  1  holding register empty
- `rx_data`  out  WIDTH  last received word, held until next word
- `rx_valid`  out  1  one-cycle pulse, rx_data updated
- `tx_underrun`  out  1  one-cycle pulse, a zero word is being clocked out
- `frame_abort`  out  1  one-cycle pulse, CS_N rose mid-word
- `busy`  out  1  state == ACTIVE

## Operation
- Leading edge = rising if CPOL=0, falling if CPOL=1. Sample edge = leading if CPHA=0, trailing if CPHA=1. Drive edge = the other edge.
- States:
  - WAIT_IDLE (reset state): goes to IDLE when synced cs_n = 1.
  - IDLE: on synced cs_n fall, perform a word load, clear bit count, go to ACTIVE.
  - ACTIVE: on synced cs_n rise, go to IDLE. If bit count ≠ 0, pulse frame_abort and discard the partial word.
- Sample edge in ACTIVE: shift mosi into the RX shift register and increment the bit count. On count = WIDTH:
  - rx_data ← assembled word; rx_valid pulses.
  - Count wraps to 0.
- Drive edge in ACTIVE:
  - CPHA=0: drive edges 1..WIDTH−1 of a word shift TX; drive edge WIDTH performs a word load.
  - CPHA=1: drive edge 1 of a word is a no-op on the first word of a frame and a word load on later words; drive edges 2..WIDTH shift.
- Word load: shift register ← holding register and holding is emptied. If holding was empty, load all zeros and arm underrun. An armed underrun pulses tx_underrun at the next sample edge, so a load after the frame's last word never flags.
- miso = current TX bit (MSB or LSB per MSB_FIRST). miso is 0 when not ACTIVE. miso_oe = busy.
- Holding register accepts on tx_valid && tx_ready. A write in the same cycle as a load goes to holding; it is never bypassed into the shift register.
- CS_N rise does not clear the holding register.

## Timing
- Reset values:
  - State WAIT_IDLE.
  - miso, miso_oe, busy, rx_valid, tx_underrun, frame_abort = 0.
  - rx_data = 0; tx_ready = 1; holding empty.
  - Sync flops reset to cs_n = 1, sclk = CPOL, mosi = 0.
- Pin-to-edge-detect latency: SYNC_STAGES + 1 clk.
- miso updates SYNC_STAGES + 2 clk after the pin drive edge.
- Requirement: each SCLK half-period ≥ SYNC_STAGES + 3 clk. With the default, f_clk ≥ 10 × f_sclk.
- A CPHA=0 master must wait ≥ SYNC_STAGES + 3 clk after CS_N fall before the first SCLK edge.
- rx_valid asserts SYNC_STAGES + 2 clk after the WIDTH-th sample pin edge.
- tx_ready re-asserts the cycle after a load.
- Simultaneous events:
  - cs_n rise together with an SCLK edge in the same cycle: the cs_n rise wins and the edge is ignored.
  - rst overrides everything, including mid-frame. After reset, no frame starts until CS_N has been seen high.

## Structure
- Package `spi_pkg`: state enum (WAIT_IDLE, IDLE, ACTIVE) and a `spi_mode_t` struct {cpol, cphase}.
- Sub-module `spi_sync_edge`: N-stage synchroniser plus rise/fall pulse outputs. Instantiated for sclk and cs_n; mosi uses the synchroniser only, with depth matched.
- Top module holds the FSM, bit counter ($clog2(WIDTH)+1 bits), RX/TX shift registers and holding register.

## Test plan
- Mode 0, WIDTH=8: master sends 0xA5 while tx holds 0x3C → rx_valid once with rx_data = 0xA5; master receives 0x3C.
- Modes 1–3 and MSB_FIRST=0: same exchange. LSB-first: master sending 0xA5 LSB-first yields rx_data = 0xA5 and master reads 0x3C in LSB order.
- Streaming: 3 words in one frame with tx_valid refilled after each tx_ready (0x11, 0x22, 0x33) → three rx_valid pulses; master receives 0x11/0x22/0x33; no tx_underrun.
- Underrun: second word not queued → master receives 0x00 for word 2; exactly one tx_underrun pulse, at word 2's first sample edge.
- Abort: CS_N rises after 5 bits → frame_abort pulse, no rx_valid; the next full frame receives correctly.
- Reset mid-frame with CS_N held low → busy = 0 and no activity until CS_N goes high then low again.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the oversampled SPI slave: FSM state encoding and the
// clock-mode pair, plus a helper that decides which SCLK level change is
// the sample edge.
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cphase;
  } spi_mode_t;

  // Sample edge is a rising SCLK edge for modes 0 and 3, falling for 1 and 2.
  function automatic logic sample_on_rise(spi_mode_t mode);
    return (mode.cpol == mode.cphase);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous pin followed by a registered
// edge detector. The level output is taken from the same tap as the edge
// pulses, so level and pulse refer to the same sampled transition.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Synchroniser chain, delayed copy and registered edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign q    = prev_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_slave_os.sv
// Oversampled SPI slave, fully in the clk domain. SCLK and CS_N are
// synchronised and edge-detected; MOSI is delayed through a chain of matching
// depth so it lines up with the SCLK edge pulse.
//
// Handshakes: tx_data is captured on every cycle where tx_valid && tx_ready;
// tx_ready is high exactly while the holding register is empty, and the
// producer may change tx_data freely while tx_valid is low. rx_valid is a
// one-cycle strobe without back-pressure; rx_data stays stable until the next
// strobe.
module spi_slave_os
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_abort,
  output logic             busy
);

  localparam int        CW          = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam spi_mode_t MODE        = '{cpol: (CPOL != 0), cphase: (CPHA != 0)};
  localparam logic      SAMPLE_RISE = sample_on_rise(MODE);
  // Cycles after reset before the synchronised CS_N level is trusted: the
  // synchroniser reset value says "high" even if the pin is held low.
  localparam int        SETTLE      = SYNC_STAGES + 2;
  localparam int        SW          = $clog2(SETTLE + 1);

  spi_state_t        state_q, state_d;
  logic [SW-1:0]     settle_q;
  logic              settled;

  logic              sclk_s, sclk_rise, sclk_fall;
  logic              cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES:0] mosi_sync_q;
  logic              mosi_s;
  logic              sample_edge, drive_edge;

  logic [CW-1:0]     bit_cnt_q;
  logic [WIDTH-1:0]  rx_sr_q, rx_next;
  logic [WIDTH-1:0]  tx_sr_q, tx_shifted;
  logic [WIDTH-1:0]  hold_q;
  logic              hold_full_q;
  logic              first_word_q;
  logic              unr_armed_q;
  logic [WIDTH-1:0]  rx_data_q;
  logic              rx_valid_q, tx_underrun_q, frame_abort_q;

  logic              do_load, do_sample, do_shift, frame_start, frame_end, do_abort;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL != 0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .q    (sclk_s),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (cs_n),
    .q    (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // MOSI delay chain, one stage longer than the synchroniser to match the edge tap.
  always_ff @(posedge clk) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-1:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES];

  // An edge is classified by the level SCLK settled to.
  assign sample_edge = (sclk_rise | sclk_fall) & (sclk_s == SAMPLE_RISE);
  assign drive_edge  = (sclk_rise | sclk_fall) & (sclk_s != SAMPLE_RISE);

  assign settled    = (settle_q == SW'(SETTLE));
  assign rx_next    = (MSB_FIRST != 0) ? {rx_sr_q[WIDTH-2:0], mosi_s}
                                       : {mosi_s, rx_sr_q[WIDTH-1:1]};
  assign tx_shifted = (MSB_FIRST != 0) ? {tx_sr_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, tx_sr_q[WIDTH-1:1]};

  // State register and post-reset settle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_IDLE;
      settle_q <= '0;
    end else begin
      state_q <= state_d;
      if (!settled) settle_q <= settle_q + SW'(1);
    end
  end

  // Next state and per-cycle datapath strobes; a CS_N rise masks any SCLK edge.
  always_comb begin
    state_d     = state_q;
    do_load     = 1'b0;
    do_sample   = 1'b0;
    do_shift    = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    do_abort    = 1'b0;
    case (state_q)
      WAIT_IDLE: if (settled && cs_s) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          do_load     = 1'b1;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d   = IDLE;
          frame_end = 1'b1;
          do_abort  = (bit_cnt_q != '0);
        end else if (sample_edge) begin
          do_sample = 1'b1;
        end else if (drive_edge) begin
          if (CPHA == 0) begin
            if (bit_cnt_q == '0) do_load  = 1'b1;
            else                 do_shift = 1'b1;
          end else begin
            if (bit_cnt_q == '0) do_load  = ~first_word_q;
            else                 do_shift = 1'b1;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // Shift registers, bit counter, holding register and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      first_word_q  <= 1'b0;
      unr_armed_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;

      if (do_sample) begin
        rx_sr_q <= rx_next;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_q    <= '0;
          rx_data_q    <= rx_next;
          rx_valid_q   <= 1'b1;
          first_word_q <= 1'b0;
        end else begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
        end
        if (unr_armed_q) begin
          tx_underrun_q <= 1'b1;
          unr_armed_q   <= 1'b0;
        end
      end

      if (do_load) begin
        tx_sr_q     <= hold_full_q ? hold_q : '0;
        unr_armed_q <= ~hold_full_q;
      end else if (do_shift) begin
        tx_sr_q <= tx_shifted;
      end

      if (frame_start) begin
        bit_cnt_q    <= '0;
        first_word_q <= 1'b1;
      end

      // Partial word is dropped by clearing the count; any armed underrun
      // belongs to a word that will never be clocked.
      if (frame_end) begin
        bit_cnt_q     <= '0;
        unr_armed_q   <= 1'b0;
        frame_abort_q <= do_abort;
      end

      // A write alongside a load lands in holding, never in the shifter.
      if (tx_valid && !hold_full_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end else if (do_load) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign busy        = (state_q == ACTIVE);
  assign miso_oe     = busy;
  assign miso        = busy & ((MSB_FIRST != 0) ? tx_sr_q[WIDTH-1] : tx_sr_q[0]);
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_os.sv
// Directed bench for spi_slave_os: five instances cover modes 0-3 and
// LSB-first; a behavioural SPI master drives the selected one.
module tb_spi_slave_os;

  localparam int W  = 8;
  localparam int NI = 5;
  localparam int H  = 8;   // SCLK half-period in clk cycles
  // Instance i: bit i of each table. 0:mode0 1:mode1 2:mode2 3:mode3 4:mode0 LSB-first
  localparam bit [NI-1:0] CPOL_T = 5'b01100;
  localparam bit [NI-1:0] CPHA_T = 5'b01010;
  localparam bit [NI-1:0] MSB_T  = 5'b01111;

  // ---- clock / reset ----
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---- master pins and per-instance wiring ----
  logic          sclk_lvl = 1'b0;
  logic          cs_n_m   = 1'b1;
  logic          mosi     = 1'b0;
  logic [W-1:0]  tx_data  = '0;
  logic          tx_valid = 1'b0;
  int            sel      = 0;

  logic [NI-1:0] sclk_v, cs_n_v, tx_valid_v;
  logic [NI-1:0] miso_v, miso_oe_v, tx_ready_v, rx_valid_v, unr_v, abt_v, busy_v;
  logic [W-1:0]  rx_data_v [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    assign sclk_v[gi]     = sclk_lvl ^ CPOL_T[gi];
    assign cs_n_v[gi]     = (sel == gi) ? cs_n_m : 1'b1;
    assign tx_valid_v[gi] = tx_valid && (sel == gi);

    spi_slave_os #(
      .WIDTH(W), .CPOL(int'(CPOL_T[gi])), .CPHA(int'(CPHA_T[gi])),
      .MSB_FIRST(int'(MSB_T[gi])), .SYNC_STAGES(2)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .sclk        (sclk_v[gi]),
      .cs_n        (cs_n_v[gi]),
      .mosi        (mosi),
      .miso        (miso_v[gi]),
      .miso_oe     (miso_oe_v[gi]),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid_v[gi]),
      .tx_ready    (tx_ready_v[gi]),
      .rx_data     (rx_data_v[gi]),
      .rx_valid    (rx_valid_v[gi]),
      .tx_underrun (unr_v[gi]),
      .frame_abort (abt_v[gi]),
      .busy        (busy_v[gi])
    );
  end

  // ---- scoreboard ----
  int           passed = 0;
  int           total  = 0;
  int           rx_cnt  [NI] = '{default: 0};
  int           unr_cnt [NI] = '{default: 0};
  int           abt_cnt [NI] = '{default: 0};
  logic [W-1:0] exp_q [$];
  logic [W-1:0] mi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Every rx_valid strobe is checked against the oldest expected word.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        if (rx_valid_v[i]) begin
          rx_cnt[i]++;
          if (exp_q.size() > 0) chk($sformatf("rx_data_inst%0d", i), 32'(rx_data_v[i]), 32'(exp_q.pop_front()));
          else begin
            total++;
            $error("FAIL rx_unexpected_inst%0d: observed 0x%0h expected no word", i, rx_data_v[i]);
          end
        end
        if (unr_v[i]) unr_cnt[i]++;
        if (abt_v[i]) abt_cnt[i]++;
      end
    end
  end

  // ---- driver tasks ----
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_tx(input logic [W-1:0] d);
    int t = 0;
    while (!tx_ready_v[sel] && t < 50) begin
      clks(1);
      t++;
    end
    chk("tx_ready_before_write", 32'(tx_ready_v[sel]), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    clks(1);
    tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    cs_n_m = 1'b0;
    clks(H);
  endtask

  task automatic cs_high();
    clks(H);
    cs_n_m = 1'b1;
    clks(2 * H);
  endtask

  // Master: drives on its drive edge, samples miso on its sample edge.
  task automatic xfer(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] rd);
    logic b, rbit;
    bit   cpha, msb;
    cpha = CPHA_T[sel];
    msb  = MSB_T[sel];
    rd   = '0;
    for (int j = 0; j < nbits; j++) begin
      b = msb ? mo[W-1-j] : mo[j];
      if (!cpha) begin
        mosi = b;
        clks(H);
        sclk_lvl = 1'b1;
        rbit = miso_v[sel];
        clks(H);
        sclk_lvl = 1'b0;
      end else begin
        sclk_lvl = 1'b1;
        mosi = b;
        clks(H);
        sclk_lvl = 1'b0;
        rbit = miso_v[sel];
        clks(H);
      end
      rd = msb ? {rd[W-2:0], rbit} : {rbit, rd[W-1:1]};
    end
  endtask

  // ---- watchdog ----
  initial begin
    #1000000;
    total++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("%0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

  // ---- directed sequence ----
  initial begin
    clks(4);
    rst = 1'b0;
    chk("rst_busy",        32'(busy_v[0]),     32'd0);
    chk("rst_miso_oe",     32'(miso_oe_v[0]),  32'd0);
    chk("rst_miso",        32'(miso_v[0]),     32'd0);
    chk("rst_rx_valid",    32'(rx_valid_v[0]), 32'd0);
    chk("rst_tx_underrun", 32'(unr_v[0]),      32'd0);
    chk("rst_frame_abort", 32'(abt_v[0]),      32'd0);
    chk("rst_rx_data",     32'(rx_data_v[0]),  32'd0);
    chk("rst_tx_ready",    32'(tx_ready_v[0]), 32'd1);
    clks(10);

    // One 0xA5 / 0x3C exchange per mode and bit order.
    for (int i = 0; i < NI; i++) begin
      sel = i;
      write_tx(8'h3C);
      cs_low();
      chk($sformatf("mode%0d_busy", i), 32'(busy_v[i]), 32'd1);
      exp_q.push_back(8'hA5);
      xfer(8'hA5, W, mi);
      cs_high();
      chk($sformatf("mode%0d_master_rx", i), 32'(mi), 32'h3C);
      chk($sformatf("mode%0d_rx_count", i), 32'(rx_cnt[i]), 32'd1);
      chk($sformatf("mode%0d_idle_after", i), 32'(busy_v[i]), 32'd0);
    end

    // Streaming three words in one frame, mode 0.
    sel = 0;
    write_tx(8'h11);
    cs_low();
    write_tx(8'h22);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3);
    xfer(8'hA1, W, mi);
    chk("stream_w1", 32'(mi), 32'h11);
    write_tx(8'h33);
    xfer(8'hB2, W, mi);
    chk("stream_w2", 32'(mi), 32'h22);
    xfer(8'hC3, W, mi);
    chk("stream_w3", 32'(mi), 32'h33);
    cs_high();
    chk("stream_rx_count", 32'(rx_cnt[0]), 32'd4);
    chk("stream_no_underrun", 32'(unr_cnt[0]), 32'd0);

    // Underrun: only the first word is queued.
    write_tx(8'hC3);
    cs_low();
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h96);
    xfer(8'h5A, W, mi);
    chk("unr_w1", 32'(mi), 32'hC3);
    chk("unr_none_yet", 32'(unr_cnt[0]), 32'd0);
    xfer(8'h96, W, mi);
    chk("unr_w2_zero", 32'(mi), 32'h00);
    cs_high();
    chk("unr_one_pulse", 32'(unr_cnt[0]), 32'd1);
    chk("unr_rx_count", 32'(rx_cnt[0]), 32'd6);

    // Abort after five bits, then a clean frame.
    write_tx(8'h77);
    cs_low();
    xfer(8'hFF, 5, mi);
    cs_high();
    chk("abort_pulse", 32'(abt_cnt[0]), 32'd1);
    chk("abort_no_rx", 32'(rx_cnt[0]), 32'd6);
    write_tx(8'hE1);
    cs_low();
    exp_q.push_back(8'h3C);
    xfer(8'h3C, W, mi);
    cs_high();
    chk("post_abort_master_rx", 32'(mi), 32'hE1);
    chk("post_abort_rx_count", 32'(rx_cnt[0]), 32'd7);
    chk("post_abort_abort_count", 32'(abt_cnt[0]), 32'd1);

    // Reset mid-frame with CS_N held low.
    write_tx(8'h42);
    cs_low();
    write_tx(8'h99);
    chk("pre_reset_holding_full", 32'(tx_ready_v[0]), 32'd0);
    xfer(8'hFF, 3, mi);
    rst = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(30);
    chk("mid_rst_busy", 32'(busy_v[0]), 32'd0);
    chk("mid_rst_miso_oe", 32'(miso_oe_v[0]), 32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready_v[0]), 32'd1);
    for (int k = 0; k < 2; k++) begin
      sclk_lvl = 1'b1;
      clks(H);
      sclk_lvl = 1'b0;
      clks(H);
    end
    chk("mid_rst_still_idle", 32'(busy_v[0]), 32'd0);
    chk("mid_rst_no_rx", 32'(rx_cnt[0]), 32'd7);
    cs_n_m = 1'b1;
    clks(2 * H);
    chk("mid_rst_cs_high_idle", 32'(busy_v[0]), 32'd0);
    cs_low();
    chk("mid_rst_new_frame_busy", 32'(busy_v[0]), 32'd1);
    exp_q.push_back(8'h81);
    xfer(8'h81, W, mi);
    cs_high();
    chk("mid_rst_empty_load", 32'(mi), 32'h00);
    chk("mid_rst_rx_count", 32'(rx_cnt[0]), 32'd8);

    clks(4);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
